// File: rtl/prt_led_pkg.sv
// prt_led_pkg: shared mode/state types and constants for the LED controller
package prt_led_pkg;
  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_e;
  typedef enum logic [2:0] {S_OFF, S_ON, S_PULSE_ON, S_PULSE_OFF, S_GAP} state_e;
  localparam logic [3:0] GAP_LEN = 4'd8;
  function automatic state_e start_state(mode_e m, logic [3:0] cnt);
    return m == M_OFF ? S_OFF : m == M_ON ? S_ON : (m == M_BURST && cnt == '0) ? S_OFF : S_PULSE_ON;
  endfunction
endpackage

// File: rtl/prt_led_ch.sv
// prt_led_ch: one LED channel (config registers, blink/burst FSM, optional PRT_LED_PWM_EN duty gate)
module prt_led_ch
  import prt_led_pkg::*;
#(
  parameter int P_IDX      = 0,
  parameter int P_PERIOD_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [3:0]            cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [P_PERIOD_W-1:0] cfg_period,
  input  logic [3:0]            cfg_cnt,
  input  logic                  sync,
  input  logic                  tick,
`ifdef PRT_LED_PWM_EN
  input  logic [7:0]            cfg_duty,
  input  logic [7:0]            pwm,
`endif
  output logic                  led
);
  mode_e                 mode_q, mode_d;
  state_e                state_q, state_d;
  logic [P_PERIOD_W-1:0] period_q, period_d, phase_q, phase_d, ph_last;
  logic [3:0]            cnt_q, cnt_d, pulse_q, pulse_d;
  logic                  led_q, led_d, wr, ph_end, burst_done, gap_done;
`ifdef PRT_LED_PWM_EN
  logic [7:0]            duty_q, duty_d;
`endif
  // config capture, restart on write/sync, phase/pulse sequencing on ticks
  always_comb begin
    wr = cfg_wr && cfg_ch == 4'(P_IDX);
    mode_d = wr ? mode_e'(cfg_mode) : mode_q;
    period_d = wr ? cfg_period : period_q;
    cnt_d = wr ? cfg_cnt : cnt_q;
    ph_last = period_q == '0 ? '0 : period_q - P_PERIOD_W'(1);
    ph_end = phase_q >= ph_last;
    burst_done = mode_q == M_BURST && pulse_q + 4'd1 == cnt_q;
    gap_done = pulse_q == GAP_LEN - 4'd1;
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    if (wr || sync) begin
      state_d = start_state(mode_d, cnt_d);
      phase_d = '0;
      pulse_d = '0;
    end else if (tick && state_q inside {S_PULSE_ON, S_PULSE_OFF, S_GAP}) begin
      phase_d = ph_end ? '0 : phase_q + P_PERIOD_W'(1);
      if (ph_end) begin
        state_d = state_q == S_PULSE_ON ? S_PULSE_OFF :
                  state_q == S_PULSE_OFF ? (burst_done ? S_GAP : S_PULSE_ON) :
                  (gap_done ? S_PULSE_ON : S_GAP);
        pulse_d = state_q == S_PULSE_ON ? pulse_q :
                  state_q == S_PULSE_OFF ? ((burst_done || mode_q != M_BURST) ? '0 : pulse_q + 4'd1) :
                  (gap_done ? '0 : pulse_q + 4'd1);
      end
    end
    led_d = state_d == S_ON || state_d == S_PULSE_ON;
`ifdef PRT_LED_PWM_EN
    duty_d = wr ? cfg_duty : duty_q;
    led_d = led_d && pwm < duty_d;
`endif
  end
  // channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_OFF;
      state_q <= S_OFF;
      period_q <= '0;
      phase_q <= '0;
      cnt_q <= '0;
      pulse_q <= '0;
      led_q <= 1'b0;
`ifdef PRT_LED_PWM_EN
      duty_q <= 8'hFF;
`endif
    end else begin
      mode_q <= mode_d;
      state_q <= state_d;
      period_q <= period_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
      led_q <= led_d;
`ifdef PRT_LED_PWM_EN
      duty_q <= duty_d;
`endif
    end
  end
  assign led = led_q;
endmodule

// File: rtl/prt_led_ctl.sv
// prt_led_ctl: multi-channel LED controller with shared tick prescaler; PRT_LED_PWM_EN adds duty gating
module prt_led_ctl
  import prt_led_pkg::*;
#(
  parameter int P_CHANNELS = 4,
  parameter int P_PRESCALE = 100000,
  parameter int P_PERIOD_W = 8
) (
  input  logic                  CLK_IN,
  input  logic                  RST_IN,
  input  logic                  CFG_WR_IN,
  input  logic [3:0]            CFG_CH_IN,
  input  logic [1:0]            CFG_MODE_IN,
  input  logic [P_PERIOD_W-1:0] CFG_PERIOD_IN,
  input  logic [3:0]            CFG_CNT_IN,
  input  logic [7:0]            CFG_DUTY_IN,
  input  logic                  SYNC_IN,
  output logic [P_CHANNELS-1:0] LED_OUT
);
  localparam int PRE_W = $clog2(P_PRESCALE);
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
`ifdef PRT_LED_PWM_EN
  logic [7:0]       pwm_q, pwm_d;
`else
  logic             unused_duty;
  assign unused_duty = ^CFG_DUTY_IN;
`endif
  // shared prescaler: tick on the cycle it wraps, SYNC realigns it
  always_comb begin
    tick = pre_q == PRE_W'(P_PRESCALE - 1);
    pre_d = (SYNC_IN || tick) ? '0 : pre_q + PRE_W'(1);
`ifdef PRT_LED_PWM_EN
    pwm_d = pwm_q + 8'd1;
`endif
  end
  // prescaler and free-running PWM counter registers
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      pre_q <= '0;
`ifdef PRT_LED_PWM_EN
      pwm_q <= '0;
`endif
    end else begin
      pre_q <= pre_d;
`ifdef PRT_LED_PWM_EN
      pwm_q <= pwm_d;
`endif
    end
  end
  for (genvar i = 0; i < P_CHANNELS; i++) begin : g_ch
    prt_led_ch #(
      .P_IDX      (i),
      .P_PERIOD_W (P_PERIOD_W)
    ) u_ch (
      .clk        (CLK_IN),
      .rst        (RST_IN),
      .cfg_wr     (CFG_WR_IN),
      .cfg_ch     (CFG_CH_IN),
      .cfg_mode   (CFG_MODE_IN),
      .cfg_period (CFG_PERIOD_IN),
      .cfg_cnt    (CFG_CNT_IN),
      .sync       (SYNC_IN),
      .tick       (tick),
`ifdef PRT_LED_PWM_EN
      .cfg_duty   (CFG_DUTY_IN),
      .pwm        (pwm_q),
`endif
      .led        (LED_OUT[i])
    );
  end
endmodule

// File: doc/prt_led_ctl.md
PRT_LED_CTL -- requirements
Module: prt_led_ctl

Interface
REQ-001 Parameter P_CHANNELS, default 4: number of independent LED channels, range 1..16.
REQ-002 Parameter P_PRESCALE, default 100000: clock cycles per tick, minimum 2.
REQ-003 Parameter P_PERIOD_W, default 8: width of the per-channel period field.
REQ-004 CLK_IN  input  1  single clock; all logic synchronous to its rising edge.
REQ-005 RST_IN  input  1  reset, synchronous, active-high.
REQ-006 CFG_WR_IN  input  1  single-cycle configuration write strobe.
REQ-007 CFG_CH_IN  input  4  target channel index.
REQ-008 CFG_MODE_IN  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-009 CFG_PERIOD_IN  input  P_PERIOD_W  phase length in ticks.
REQ-010 CFG_CNT_IN  input  4  pulses per burst (BURST mode only).
REQ-011 CFG_DUTY_IN  input  8  brightness duty (PRT_LED_PWM_EN builds only; ignored otherwise).
REQ-012 SYNC_IN  input  1  single-cycle strobe realigning all channels' phase.
REQ-013 LED_OUT  output  P_CHANNELS  registered LED drive, bit i = channel i.

Function
REQ-014 The block SHALL run one shared prescaler counting 0..P_PRESCALE-1 and SHALL assert an internal one-cycle tick on the cycle it wraps to 0.
REQ-015 Each channel SHALL hold its mode, period, count and duty in registers written when CFG_WR_IN=1 and CFG_CH_IN equals the channel index; writes with CFG_CH_IN >= P_CHANNELS SHALL be ignored.
REQ-016 Each channel SHALL implement states S_OFF, S_ON, S_PULSE_ON, S_PULSE_OFF and S_GAP, plus a phase counter of P_PERIOD_W bits and a pulse counter of 4 bits.
REQ-017 A write SHALL restart the channel: phase and pulse counters cleared; next state S_OFF (mode 0), S_ON (mode 1), or S_PULSE_ON (modes 2, 3).
REQ-018 LED_OUT[i] SHALL reflect the new state one cycle after the write cycle (registered output, latency 1).
REQ-019 The phase counter SHALL advance only on ticks; a phase ends on the tick at which the counter reaches max(period,1)-1, and a period of 0 SHALL behave as 1.
REQ-020 BLINK: S_PULSE_ON -> S_PULSE_OFF -> S_PULSE_ON at each phase end, indefinitely.
REQ-021 BURST: after CNT completed S_PULSE_ON/S_PULSE_OFF pairs, the channel SHALL enter S_GAP for 8 phases, then return to S_PULSE_ON with the pulse count cleared; CNT=0 SHALL behave as OFF.
REQ-022 LED_OUT[i] SHALL be 1 in S_ON and S_PULSE_ON, 0 otherwise (before PWM gating).
REQ-023 SYNC_IN SHALL restart every channel as in REQ-017 using its current mode and SHALL clear the prescaler.
REQ-024 Precedence when events coincide on one channel: RST_IN > CFG write > SYNC_IN > tick.
REQ-025 Phase counter wrap SHALL never occur; counters SHALL saturate at phase end and clear.

Reset
REQ-026 While RST_IN=1, the block SHALL clear the prescaler and set every channel to S_OFF, mode 0, period 0, count 0 and duty 8'hFF.
REQ-027 LED_OUT SHALL be all zeros on the cycle after RST_IN is sampled high.
REQ-028 A reset mid-phase or mid-burst SHALL discard all state, with no residual pulse after reset release.

Configuration
REQ-029 With PRT_LED_PWM_EN defined, a free-running 8-bit PWM counter SHALL gate each output: LED_OUT[i] = state_on & (pwm_cnt < duty_i), so duty 0 forces the output off.
REQ-030 Without PRT_LED_PWM_EN, the PWM counter and duty registers SHALL be absent, CFG_DUTY_IN SHALL be unused, and LED_OUT SHALL equal the ungated state.

Structure
REQ-031 Package prt_led_pkg SHALL hold the mode enum (OFF/ON/BLINK/BURST), the channel state enum and the gap length constant (8).
REQ-032 Sub-module prt_led_ch SHALL implement one channel (registers, state machine, optional PWM gate), instantiated P_CHANNELS times by generate; the prescaler and PWM counter SHALL reside in prt_led_ctl.

Verification (P_CHANNELS=4, P_PRESCALE=4, P_PERIOD_W=8)
REQ-033 Reset, then idle 100 cycles -> LED_OUT=4'b0000 throughout.
REQ-034 Write ch0 BLINK period 2 -> LED_OUT[0]=1 from the next cycle, then toggles every 8 cycles (two ticks); other bits stay 0.
REQ-035 Write ch1 BURST period 1 cnt 3 -> three 4-cycle-high/4-cycle-low pulses, then 32 cycles low, repeating.
REQ-036 Write ch2 ON, then write ch2 with period 0 BLINK -> behaves as period 1 (toggle every 4 cycles); write with CFG_CH_IN=5 -> no change on any output.
REQ-037 Two BLINK channels started at offset times, then SYNC_IN -> both outputs high on the next cycle and toggle in phase afterwards; RST_IN asserted mid-burst -> all outputs 0 the next cycle.
REQ-038 PRT_LED_PWM_EN build: ch3 ON with duty 64 -> LED_OUT[3] high for 64 of every 256 cycles; duty 0 -> constantly low.
